control_sequencer: RTL
======================

# control_sequencer

Microcoded control sequencer for the 8-bit SAP-style CPU. It steps through a fixed five-step microcycle for each instruction and decodes the 4-bit opcode held in the instruction register. It drives the 16-bit control word that steers the bus, registers, program counter and ALU (including the `sub` select). It also holds the flags register that latches the ALU zero and carry outputs, and uses those flags to resolve conditional jumps.

## Interface
- No parameters; all widths are fixed.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `en`  input  1  step enable. Step counter, flags and halt latch update only on edges where `en`=1.
- `instr`  input  4  opcode (instruction register upper nibble). Valid from step T2 onward.
- `zero_in`  input  1  ALU zero flag, combinational from the ALU.
- `carry_in`  input  1  ALU carry flag, combinational from the ALU.
- `ctrl`  output  16  control word. Bit assignment, 15 down to 0: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
- `step`  output  3  current microstep, 0–4.
- `zf`  output  1  registered zero flag.
- `cf`  output  1  registered carry flag.
- `halted`  output  1  halt latch.

## Operation
- **Step counter.** Counts 0→1→2→3→4→0. It advances only when `en`=1 and `halted`=0. It never takes values 5–7.
- **T0 and T1** are independent of `instr`:
  - T0: MI|CO = 0x4004.
  - T1: RO|II|CE = 0x1408.
- **T2/T3/T4 by opcode.** Anything not listed outputs 0x0000.
  - LDA 0001: IO|MI 0x4800 / RO|AI 0x1200 / 0.
  - ADD 0010: 0x4800 / RO|BI 0x1020 / EO|AI|FI 0x0281.
  - SUB 0011: 0x4800 / 0x1020 / EO|AI|SU|FI 0x02C1.
  - STA 0100: 0x4800 / AO|RI 0x2100 / 0.
  - LDI 0101: IO|AI 0x0A00 / 0 / 0.
  - JMP 0110: IO|J 0x0802 / 0 / 0.
  - JC 0111: T2 = 0x0802 if `cf`, else IO 0x0800. T3/T4 = 0.
  - JZ 1000: T2 = 0x0802 if `zf`, else 0x0800. T3/T4 = 0.
  - OUT 1110: AO|OI 0x0110 / 0 / 0.
  - HLT 1111: HLT 0x8000 at T2.
  - NOP 0000 and opcodes 1001–1101: 0x0000 at T2–T4. All instructions still take 5 steps; there is no early termination.
- **Flags register.** On an edge with `en`=1 and `ctrl`[0] (FI)=1: `zf`←`zero_in`, `cf`←`carry_in`. Otherwise the flags hold.
  - Conditional jumps use the registered flags, never the live inputs.
- **Halt.** On an edge with `en`=1 while `ctrl`=0x8000 (HLT at T2), `halted`←1.
  - While `halted`=1: `ctrl`=0x8000, step is frozen, flags are frozen.
  - Only `rst` clears the halt latch.
- **Reset.**
  - While `rst`=1, `ctrl` is forced to 0x0000.
  - On the first edge with `rst`=1: `step`=0, `zf`=0, `cf`=0, `halted`=0.
  - `rst` has priority over `en` and over halt.
- `ctrl` is combinational from `step`, `instr`, `zf`, `cf`, `halted` and `rst`. It is glitch-tolerant by construction because downstream registers sample on the same edge.

## Timing
- Latency: one instruction = 5 enabled clocks. Each control word is valid for the whole cycle, and its effect takes place on the closing edge.
- `instr` is loaded by II at the T1→T2 edge, so decode sees the new opcode from T2.
- A flag update from ADD/SUB T4 is visible at the next instruction's T0. A JC/JZ immediately following sees the new flags.
- Clocks with `en`=0: no state changes, and `ctrl` stays constant as long as `instr` is stable.
- First instruction after reset release: `ctrl`=0x4004 in the cycle immediately after the last `rst`=1 edge.
- Reset mid-instruction (any step, including halted): the next cycle is step 0 with flags cleared. No partial-instruction state survives.

## Test plan
- Reset: hold `rst`=1 for 2 clocks.
  - During reset: `ctrl`=0x0000.
  - Afterwards: `step`=0, `ctrl`=0x4004, `zf`=`cf`=`halted`=0.
- LDI sequence: `instr`=0101, `en`=1.
  - `ctrl` sequence 0x4004, 0x1408, 0x0A00, 0x0000, 0x0000.
  - Then `step` wraps to 0.
- SUB then JZ/JC:
  - SUB T4 with `zero_in`=1, `carry_in`=0 → `ctrl`=0x02C1; after the edge `zf`=1, `cf`=0.
  - Following JZ → T2 `ctrl`=0x0802.
  - Following JC → T2 `ctrl`=0x0800.
- Enable gating: ADD at T4 (`ctrl`=0x0281) with `en`=0 for 3 clocks and `zero_in` toggling.
  - `step` stays 4 and `zf`/`cf` are unchanged.
  - Then `en`=1 → flags capture, `step`=0.
- Halt: HLT T2 → `ctrl`=0x8000.
  - After the edge `halted`=1, and `ctrl` stays 0x8000 with `step`=2 for 10 clocks with `en`=1.
  - Then `rst` → `ctrl`=0x4004.
- Reset mid-op: assert `rst` at ADD T3 after flags were set to 1/1.
  - Next cycle: `step`=0, `zf`=`cf`=0.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - five-step microcoded control sequencer with flags and halt latch
//
// Purpose: steps T0..T4 per instruction, decodes the 4-bit opcode into the
// 16-bit control word, latches ALU zero/carry on FI and latches HLT.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset
//   en        step enable; step, flags and halt latch update only when high
//   instr     opcode (valid from T2)
//   zero_in   live ALU zero flag
//   carry_in  live ALU carry flag
//   ctrl      control word: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
//   step      current microstep 0..4
//   zf, cf    registered flags
//   halted    halt latch
module control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  instr,
  input  logic        zero_in,
  input  logic        carry_in,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        zf,
  output logic        cf,
  output logic        halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [15:0] HALT_WORD = 16'h8000;

  step_t       state, state_next;
  logic        zf_next, cf_next, halted_next;
  logic [15:0] ucode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      zf     <= zf_next;
      cf     <= cf_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    ucode       = 16'h0000;
    state_next  = state;
    zf_next     = zf;
    cf_next     = cf;
    halted_next = halted;

    case (state)
      T0: ucode = 16'h4004;
      T1: ucode = 16'h1408;
      T2: begin
        case (instr)
          4'b0001, 4'b0010, 4'b0011, 4'b0100: ucode = 16'h4800;
          4'b0101: ucode = 16'h0A00;
          4'b0110: ucode = 16'h0802;
          // Conditional jumps look at the registered flags only.
          4'b0111: ucode = cf ? 16'h0802 : 16'h0800;
          4'b1000: ucode = zf ? 16'h0802 : 16'h0800;
          4'b1110: ucode = 16'h0110;
          4'b1111: ucode = HALT_WORD;
          default: ucode = 16'h0000;
        endcase
      end
      T3: begin
        case (instr)
          4'b0001: ucode = 16'h1200;
          4'b0010, 4'b0011: ucode = 16'h1020;
          4'b0100: ucode = 16'h2100;
          default: ucode = 16'h0000;
        endcase
      end
      T4: begin
        case (instr)
          4'b0010: ucode = 16'h0281;
          4'b0011: ucode = 16'h02C1;
          default: ucode = 16'h0000;
        endcase
      end
      default: ucode = 16'h0000;
    endcase

    if (rst) begin
      ctrl = 16'h0000;
    end else if (halted) begin
      ctrl = HALT_WORD;
    end else begin
      ctrl = ucode;
    end

    if (en && !rst) begin
      if (ctrl[0]) begin
        zf_next = zero_in;
        cf_next = carry_in;
      end
      // HLT freezes the counter at T2 on the very edge that sets the latch.
      if (ctrl == HALT_WORD) begin
        halted_next = 1'b1;
      end else begin
        case (state)
          T0:      state_next = T1;
          T1:      state_next = T2;
          T2:      state_next = T3;
          T3:      state_next = T4;
          default: state_next = T0;
        endcase
      end
    end
  end

  assign step = state;

endmodule
